pp_column_loader: RTL and testbench

- Parametrised serial-to-parallel loader for the partial-product dot matrix of an N×N multiplier compressor.
- Each cycle it accepts one bit per column (2N-1 columns) and shifts it into that column's register.
- Column height h(i) = min(i+1, 2N-1-i).
- After N accepted beats it presents the full matrix, flattened, to the downstream compressor through a valid/ready handshake.
- Generalises the fixed 17-bit free-running loader: any width, handshakes on both sides, a beat counter, flush, and a selectable clear-on-pop mode.

---
 rtl/pp_column_loader_if.sv | 32 +++
 rtl/pp_column_loader.sv | 108 ++++++++++
 tb/tb_pp_column_loader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pp_column_loader_if.sv
// Handshake bundle between the upstream beat source, the column loader and
// the downstream compressor.
//   in_valid/in_ready/din : one bit per column per beat (2N-1 columns)
//   out_valid/out_ready   : matrix handoff
//   dout                  : flattened N*N dot matrix
//   beat_cnt              : beats currently held (0..N)
// master = side driving beats and consuming the matrix, slave = loader.
interface pp_column_loader_if #(
  parameter int unsigned N = 17
);
  localparam int unsigned COLS = 2 * N - 1;
  localparam int unsigned MW   = N * N;
  localparam int unsigned CW   = $clog2(N + 1);

  logic            in_valid;
  logic            in_ready;
  logic [COLS-1:0] din;
  logic            out_valid;
  logic            out_ready;
  logic [MW-1:0]   dout;
  logic [CW-1:0]   beat_cnt;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, beat_cnt
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, beat_cnt
  );
endinterface

// File: rtl/pp_column_loader.sv
// Serial-to-parallel loader for the partial-product dot matrix of an NxN
// multiplier compressor. Each accepted beat shifts din[i] into column i;
// column i keeps its last h(i) = min(i+1, 2N-1-i) bits. After N beats the
// flattened matrix is offered downstream over a valid/ready handshake.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous clear of counter and columns, overrides accept/pop
//   bus    : pp_column_loader_if.slave (beat input, matrix output, beat_cnt)
// The interface instance must be built with the same N as this module.
module pp_column_loader #(
  parameter int unsigned N            = 17,
  parameter bit          CLEAR_ON_POP = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  pp_column_loader_if.slave     bus
);

  localparam int unsigned COLS = 2 * N - 1;
  localparam int unsigned MW   = N * N;
  localparam int unsigned CW   = $clog2(N + 1);

  // Height of column i in the dot matrix.
  function automatic int unsigned col_h(input int unsigned i);
    return ((i + 1) < (COLS - i)) ? (i + 1) : (COLS - i);
  endfunction

  // Bit offset of column i inside the flattened matrix.
  function automatic int unsigned col_off(input int unsigned i);
    int unsigned s;
    s = 0;
    for (int unsigned k = 0; k < i; k++) begin
      s += col_h(k);
    end
    return s;
  endfunction

  logic [MW-1:0] matrix_q;
  logic [MW-1:0] matrix_d;
  logic [MW-1:0] shift_c;
  logic [MW-1:0] lsb_c;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          full_c;
  logic          in_ready_c;
  logic          accept_c;
  logic          pop_c;

  // Handshake decode; in_ready only looks at out_ready combinationally.
  assign full_c     = (cnt_q == CW'(N));
  assign in_ready_c = !full_c || bus.out_ready;
  assign accept_c   = bus.in_valid && in_ready_c;
  assign pop_c      = full_c && bus.out_ready;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = full_c;
  assign bus.dout      = matrix_q;
  assign bus.beat_cnt  = cnt_q;

  // Per-column candidates: shifted-in column, or column holding only the new bit.
  // Newest bit sits at the column LSB; the oldest falls off the top.
  for (genvar i = 0; i < COLS; i++) begin : g_col
    localparam int unsigned H   = col_h(i);
    localparam int unsigned OFF = col_off(i);
    if (H == 1) begin : g_h1
      assign shift_c[OFF] = bus.din[i];
      assign lsb_c[OFF]   = bus.din[i];
    end else begin : g_hn
      assign shift_c[OFF +: H] = {matrix_q[OFF +: (H - 1)], bus.din[i]};
      assign lsb_c[OFF +: H]   = {{(H - 1){1'b0}}, bus.din[i]};
    end
  end

  // Next-state: flush > pop&accept > pop > accept > hold.
  always_comb begin
    matrix_d = matrix_q;
    cnt_d    = cnt_q;
    if (flush) begin
      matrix_d = '0;
      cnt_d    = '0;
    end else if (pop_c && accept_c) begin
      matrix_d = CLEAR_ON_POP ? lsb_c : shift_c;
      cnt_d    = CW'(1);
    end else if (pop_c) begin
      if (CLEAR_ON_POP) begin
        matrix_d = '0;
      end
      cnt_d = '0;
    end else if (accept_c) begin
      matrix_d = shift_c;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matrix_q <= '0;
      cnt_q    <= '0;
    end else begin
      matrix_q <= matrix_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pp_column_loader.sv
// Bench for pp_column_loader at N=4: one instance per CLEAR_ON_POP mode,
// both fed the same stimulus, each checked against its own column model.
module tb_pp_column_loader;

  localparam int unsigned N    = 4;
  localparam int unsigned COLS = 7;
  localparam int unsigned MW   = 16;
  localparam int unsigned CW   = 3;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic            flush     = 1'b0;
  logic            in_valid  = 1'b0;
  logic            out_ready = 1'b0;
  logic [COLS-1:0] din       = '0;

  pp_column_loader_if #(.N(N)) bus_c ();
  pp_column_loader_if #(.N(N)) bus_k ();

  assign bus_c.in_valid  = in_valid;
  assign bus_c.din       = din;
  assign bus_c.out_ready = out_ready;
  assign bus_k.in_valid  = in_valid;
  assign bus_k.din       = din;
  assign bus_k.out_ready = out_ready;

  pp_column_loader #(.N(N), .CLEAR_ON_POP(1'b1)) u_dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_c)
  );

  pp_column_loader #(.N(N), .CLEAR_ON_POP(1'b0)) u_dut_k (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_k)
  );

  always #5 clk = ~clk;

  // Index 0 = clear-on-pop instance, 1 = keep instance.
  logic [MW-1:0] dout_w [2];
  logic [CW-1:0] cnt_w  [2];
  logic          ov_w   [2];
  logic          ir_w   [2];
  assign dout_w[0] = bus_c.dout;
  assign dout_w[1] = bus_k.dout;
  assign cnt_w[0]  = bus_c.beat_cnt;
  assign cnt_w[1]  = bus_k.beat_cnt;
  assign ov_w[0]   = bus_c.out_valid;
  assign ov_w[1]   = bus_k.out_valid;
  assign ir_w[0]   = bus_c.in_ready;
  assign ir_w[1]   = bus_k.in_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per column, newest bit at bit 0.
  logic [3:0]    mcols [2][COLS];
  int            mcnt  [2];
  logic [MW-1:0] sb_c [$];
  logic [MW-1:0] sb_k [$];

  function automatic int col_h(input int i);
    return ((i + 1) < (COLS - i)) ? (i + 1) : (COLS - i);
  endfunction

  function automatic logic [3:0] hmask(input int i);
    logic [4:0] t;
    t = 5'(1) << col_h(i);
    return 4'(t - 5'd1);
  endfunction

  function automatic logic [MW-1:0] flat(input int m);
    logic [MW-1:0] r;
    int off;
    r   = '0;
    off = 0;
    for (int i = 0; i < COLS; i++) begin
      for (int b = 0; b < col_h(i); b++) begin
        r[off + b] = mcols[m][i][b];
      end
      off += col_h(i);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < COLS; i++) mcols[m][i] = '0;
      mcnt[m] = 0;
    end
    sb_c.delete();
    sb_k.delete();
  endtask

  // Advance both models by one clock edge using the currently driven inputs.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit full, acc, pp;
      full = (mcnt[m] == int'(N));
      acc  = in_valid && (!full || out_ready);
      pp   = full && out_ready;
      if (flush) begin
        for (int i = 0; i < COLS; i++) mcols[m][i] = '0;
        if (full) begin
          if (m == 0) void'(sb_c.pop_front());
          else        void'(sb_k.pop_front());
        end
        mcnt[m] = 0;
      end else if (pp && acc) begin
        for (int i = 0; i < COLS; i++) begin
          if (m == 0) mcols[m][i] = {3'b000, din[i]};
          else        mcols[m][i] = ((mcols[m][i] << 1) | {3'b000, din[i]}) & hmask(i);
        end
        mcnt[m] = 1;
      end else if (pp) begin
        if (m == 0) for (int i = 0; i < COLS; i++) mcols[m][i] = '0;
        mcnt[m] = 0;
      end else if (acc) begin
        for (int i = 0; i < COLS; i++)
          mcols[m][i] = ((mcols[m][i] << 1) | {3'b000, din[i]}) & hmask(i);
        mcnt[m] = mcnt[m] + 1;
      end
      if (!flush && acc && mcnt[m] == int'(N)) begin
        if (m == 0) sb_c.push_back(flat(0));
        else        sb_k.push_back(flat(1));
      end
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [COLS-1:0] d, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    din       = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step(input logic fl, input logic iv, input logic [COLS-1:0] d, input logic ordy);
    drive(fl, iv, d, ordy);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 7'h7F, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (dout_w[m] !== 16'h0000) begin
        n_fail++; $display("FAIL reset_dout dut%0d got %h want 0000", m, dout_w[m]);
      end
      n_tests++;
      if (cnt_w[m] !== 3'd0) begin
        n_fail++; $display("FAIL reset_cnt dut%0d got %0d want 0", m, cnt_w[m]);
      end
      n_tests++;
      if (ir_w[m] !== 1'b1) begin
        n_fail++; $display("FAIL reset_in_ready dut%0d got %b want 1", m, ir_w[m]);
      end
      n_tests++;
      if (ov_w[m] !== 1'b0) begin
        n_fail++; $display("FAIL reset_out_valid dut%0d got %b want 0", m, ov_w[m]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_full_load();
    step(1'b0, 1'b1, 7'h7F, 1'b0);
    step(1'b0, 1'b1, 7'h00, 1'b0);
    step(1'b0, 1'b1, 7'h7F, 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (ov_w[m] !== 1'b0 || cnt_w[m] !== 3'd3) begin
        n_fail++; $display("FAIL load_beat3 dut%0d got ov=%b cnt=%0d want ov=0 cnt=3", m, ov_w[m], cnt_w[m]);
      end
    end
    step(1'b0, 1'b1, 7'h00, 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (ov_w[m] !== 1'b1 || cnt_w[m] !== 3'd4) begin
        n_fail++; $display("FAIL load_full dut%0d got ov=%b cnt=%0d want ov=1 cnt=4", m, ov_w[m], cnt_w[m]);
      end
      n_tests++;
      if (dout_w[m] !== 16'h4A94) begin
        n_fail++; $display("FAIL load_dout dut%0d got %h want 4a94", m, dout_w[m]);
      end
      n_tests++;
      if (dout_w[m][9:6] !== 4'b1010 || dout_w[m][0] !== 1'b0 || dout_w[m][15] !== 1'b0) begin
        n_fail++; $display("FAIL load_cols dut%0d got c3=%b c0=%b c6=%b want 1010 0 0",
                           m, dout_w[m][9:6], dout_w[m][0], dout_w[m][15]);
      end
      n_tests++;
      if (ir_w[m] !== 1'b0) begin
        n_fail++; $display("FAIL load_in_ready dut%0d got %b want 0", m, ir_w[m]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b1, 7'($urandom), 1'b0);
      for (int m = 0; m < 2; m++) begin
        n_tests++;
        if (dout_w[m] !== 16'h4A94 || cnt_w[m] !== 3'd4 || ov_w[m] !== 1'b1 || ir_w[m] !== 1'b0) begin
          n_fail++; $display("FAIL hold dut%0d cyc%0d got dout=%h cnt=%0d ov=%b ir=%b want 4a94 4 1 0",
                             m, c, dout_w[m], cnt_w[m], ov_w[m], ir_w[m]);
        end
      end
    end
  endtask

  task automatic test_pop_accept();
    logic [MW-1:0] exp;
    drive(1'b0, 1'b1, 7'h01, 1'b1);
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (ir_w[m] !== 1'b1) begin
        n_fail++; $display("FAIL popacc_in_ready dut%0d got %b want 1", m, ir_w[m]);
      end
    end
    exp = (sb_c.size() > 0) ? sb_c.pop_front() : 'x;
    n_tests++;
    if (dout_w[0] !== exp) begin
      n_fail++; $display("FAIL popacc_sb dut0 got %h want %h", dout_w[0], exp);
    end
    exp = (sb_k.size() > 0) ? sb_k.pop_front() : 'x;
    n_tests++;
    if (dout_w[1] !== exp) begin
      n_fail++; $display("FAIL popacc_sb dut1 got %h want %h", dout_w[1], exp);
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (cnt_w[m] !== 3'd1 || ov_w[m] !== 1'b0) begin
        n_fail++; $display("FAIL popacc_cnt dut%0d got cnt=%0d ov=%b want 1 0", m, cnt_w[m], ov_w[m]);
      end
    end
    n_tests++;
    if (dout_w[0] !== 16'h0001) begin
      n_fail++; $display("FAIL popacc_clear_dout dut0 got %h want 0001", dout_w[0]);
    end
    n_tests++;
    if (dout_w[1] !== 16'h1121) begin
      n_fail++; $display("FAIL popacc_keep_dout dut1 got %h want 1121", dout_w[1]);
    end
    // Refill to a full matrix for the pop-only scenario.
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 7'($urandom), 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (dout_w[m] !== flat(m) || cnt_w[m] !== 3'd4) begin
        n_fail++; $display("FAIL refill dut%0d got dout=%h cnt=%0d want %h 4", m, dout_w[m], cnt_w[m], flat(m));
      end
    end
  endtask

  task automatic test_pop_only();
    logic [MW-1:0] exp_c, exp_k;
    drive(1'b0, 1'b0, 7'h00, 1'b1);
    exp_c = (sb_c.size() > 0) ? sb_c.pop_front() : 'x;
    exp_k = (sb_k.size() > 0) ? sb_k.pop_front() : 'x;
    n_tests++;
    if (dout_w[0] !== exp_c) begin
      n_fail++; $display("FAIL poponly_sb dut0 got %h want %h", dout_w[0], exp_c);
    end
    n_tests++;
    if (dout_w[1] !== exp_k) begin
      n_fail++; $display("FAIL poponly_sb dut1 got %h want %h", dout_w[1], exp_k);
    end
    tick();
    drive(1'b0, 1'b0, 7'h00, 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (cnt_w[m] !== 3'd0 || ov_w[m] !== 1'b0 || ir_w[m] !== 1'b1) begin
        n_fail++; $display("FAIL poponly_state dut%0d got cnt=%0d ov=%b ir=%b want 0 0 1", m, cnt_w[m], ov_w[m], ir_w[m]);
      end
    end
    n_tests++;
    if (dout_w[1] !== exp_k) begin
      n_fail++; $display("FAIL poponly_keep_dout dut1 got %h want %h", dout_w[1], exp_k);
    end
    n_tests++;
    if (dout_w[0] !== 16'h0000) begin
      n_fail++; $display("FAIL poponly_clear_dout dut0 got %h want 0000", dout_w[0]);
    end
  endtask

  task automatic test_flush();
    step(1'b0, 1'b1, 7'h7F, 1'b0);
    step(1'b0, 1'b1, 7'($urandom), 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (cnt_w[m] !== 3'd2 || dout_w[m] !== flat(m)) begin
        n_fail++; $display("FAIL preflush dut%0d got cnt=%0d dout=%h want 2 %h", m, cnt_w[m], dout_w[m], flat(m));
      end
    end
    step(1'b1, 1'b1, 7'h7F, 1'b1);
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (cnt_w[m] !== 3'd0 || dout_w[m] !== 16'h0000) begin
        n_fail++; $display("FAIL flush dut%0d got cnt=%0d dout=%h want 0 0000", m, cnt_w[m], dout_w[m]);
      end
    end
    drive(1'b0, 1'b0, 7'h00, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 7'h7F, 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (cnt_w[m] !== 3'd3 || dout_w[m] === 16'h0000) begin
        n_fail++; $display("FAIL prereset dut%0d got cnt=%0d dout=%h want 3 nonzero", m, cnt_w[m], dout_w[m]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_tests++;
      if (cnt_w[m] !== 3'd0 || dout_w[m] !== 16'h0000 || ov_w[m] !== 1'b0 || ir_w[m] !== 1'b1) begin
        n_fail++; $display("FAIL async_reset dut%0d got cnt=%0d dout=%h ov=%b ir=%b want 0 0000 0 1",
                           m, cnt_w[m], dout_w[m], ov_w[m], ir_w[m]);
      end
    end
    drive(1'b0, 1'b0, 7'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] exp;
    for (int c = 0; c < 3 * int'(N) + 2; c++) begin
      drive(1'b0, 1'b1, 7'($urandom), 1'b1);
      for (int m = 0; m < 2; m++) begin
        n_tests++;
        if (ov_w[m] !== (mcnt[m] == int'(N)) || ir_w[m] !== 1'b1) begin
          n_fail++; $display("FAIL b2b_hs dut%0d cyc%0d got ov=%b ir=%b want ov=%b ir=1",
                             m, c, ov_w[m], ir_w[m], (mcnt[m] == int'(N)));
        end
      end
      if (mcnt[0] == int'(N)) begin
        exp = (sb_c.size() > 0) ? sb_c.pop_front() : 'x;
        n_tests++;
        if (dout_w[0] !== exp) begin
          n_fail++; $display("FAIL b2b_sb dut0 cyc%0d got %h want %h", c, dout_w[0], exp);
        end
      end
      if (mcnt[1] == int'(N)) begin
        exp = (sb_k.size() > 0) ? sb_k.pop_front() : 'x;
        n_tests++;
        if (dout_w[1] !== exp) begin
          n_fail++; $display("FAIL b2b_sb dut1 cyc%0d got %h want %h", c, dout_w[1], exp);
        end
      end
      tick();
    end
    drive(1'b0, 1'b0, 7'h00, 1'b0);
    n_tests++;
    if (sb_c.size() != 0 || sb_k.size() != 0) begin
      n_fail++; $display("FAIL b2b_leftover got %0d/%0d entries want 0/0", sb_c.size(), sb_k.size());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_load();
    test_backpressure();
    test_pop_accept();
    test_pop_only();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
